// File: rtl/bitstream_pkg.sv
// Shared types and arithmetic helpers for stochastic bitstream decoders.
package bitstream_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        COUNT  = 2'd2,
        HOLD   = 2'd3
    } decoder_state_t;

    // Count needs WINDOW_BITS+1 bits; one more bit carries the bipolar sign.
    function automatic int res_w(input int window_bits);
        return window_bits + 2;
    endfunction

    // Maps a ones count over a 2^window_bits window onto -N..+N.
    function automatic int to_bipolar(input int count, input int window_bits);
        return 2 * count - (1 << window_bits);
    endfunction

endpackage

// File: rtl/bitstream_decoder_window_counter.sv
// Ones accumulator plus window position counter; last marks the Nth enabled sample.
module window_counter #(
    parameter int WINDOW_BITS = 8
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   clr,
    input  logic                   en,
    input  logic                   bit_in,
    output logic [WINDOW_BITS:0]   ones,
    output logic                   last
);

    logic [WINDOW_BITS-1:0] win;

    assign last = en && (win == {WINDOW_BITS{1'b1}});

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ones <= '0;
            win  <= '0;
        end else if (clr) begin
            ones <= '0;
            win  <= '0;
        end else if (en) begin
            ones <= ones + {{WINDOW_BITS{1'b0}}, bit_in};
            win  <= win + 1'b1;
        end
    end

endmodule

// File: rtl/bitstream_decoder.sv
// Stochastic bitstream to binary converter with settle period and valid/ready output.
// Define BITSTREAM_DECODER_BIPOLAR_EN for a signed 2*count-N result instead of the raw count.
module bitstream_decoder
    import bitstream_pkg::*;
#(
    parameter int WINDOW_BITS = 8,
    parameter int SKIP        = 2,
    parameter int RES_W       = res_w(WINDOW_BITS)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             bit_in,
    input  logic             start,
    input  logic             clear,
    output logic             busy,
    output logic [RES_W-1:0] result,
    output logic             result_valid,
    input  logic             result_ready
);

    localparam int SC_W = (SKIP > 1) ? $clog2(SKIP) : 1;
    localparam logic [SC_W-1:0] SETTLE_INIT = SC_W'((SKIP > 0) ? SKIP - 1 : 0);

    decoder_state_t state, next_state;
    logic [SC_W-1:0]      settle_cnt;
    logic                 window_done;
    logic                 cnt_clr, cnt_en, settle_load, settle_dec, load_result;
    logic [WINDOW_BITS:0] ones;
    logic                 last;
    logic [RES_W-1:0]     result_d;

    window_counter #(.WINDOW_BITS(WINDOW_BITS)) u_window (
        .clk    (clk),
        .n_rst  (n_rst),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .bit_in (bit_in),
        .ones   (ones),
        .last   (last)
    );

`ifdef BITSTREAM_DECODER_BIPOLAR_EN
    assign result_d = RES_W'(to_bipolar(int'(ones), WINDOW_BITS));
`else
    assign result_d = RES_W'(ones);
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state  = state;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        settle_load = 1'b0;
        settle_dec  = 1'b0;
        load_result = 1'b0;
        if (clear) begin
            next_state = IDLE;
            cnt_clr    = 1'b1;
        end else begin
            case (state)
                IDLE: if (start) begin
                    cnt_clr = 1'b1;
                    if (SKIP > 0) begin
                        next_state  = SETTLE;
                        settle_load = 1'b1;
                    end else begin
                        next_state = COUNT;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == '0) next_state = COUNT;
                    else                  settle_dec = 1'b1;
                end
                // The final sample lands one edge before the result is registered.
                COUNT: begin
                    if (window_done) begin
                        load_result = 1'b1;
                        next_state  = HOLD;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                HOLD: if (result_ready) next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            settle_cnt  <= '0;
            window_done <= 1'b0;
            result      <= '0;
        end else begin
            if (settle_load)     settle_cnt <= SETTLE_INIT;
            else if (settle_dec) settle_cnt <= settle_cnt - 1'b1;

            if (cnt_clr || load_result) window_done <= 1'b0;
            else if (cnt_en && last)    window_done <= 1'b1;

            if (load_result) result <= result_d;
        end
    end

    assign busy         = (state == SETTLE) || (state == COUNT);
    assign result_valid = (state == HOLD);

endmodule

// File: tb/tb_bitstream_decoder.sv
// Directed table-driven bench for bitstream_decoder with N=16, SKIP=2.
module tb_bitstream_decoder;

    localparam int WB   = 4;
    localparam int N    = 16;
    localparam int SKIP = 2;
    localparam int RW   = 6;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          bit_in;
    logic          start;
    logic          clear;
    logic          busy;
    logic [RW-1:0] result;
    logic          result_valid;
    logic          result_ready;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string name;
        int    mode;
        int    exp_count;
        bit    poke_start;
    } vec_t;

    vec_t vecs[4];

    bitstream_decoder #(.WINDOW_BITS(WB), .SKIP(SKIP)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .bit_in       (bit_in),
        .start        (start),
        .clear        (clear),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int exp_res(input int count);
        logic [RW-1:0] t;
`ifdef BITSTREAM_DECODER_BIPOLAR_EN
        t = RW'(2 * count - N);
`else
        t = RW'(count);
`endif
        return int'(t);
    endfunction

    function automatic int decoded_count(input logic [RW-1:0] r);
`ifdef BITSTREAM_DECODER_BIPOLAR_EN
        return (int'($signed(r)) + N) / 2;
`else
        return int'(r);
`endif
    endfunction

    function automatic logic gen(input int mode, input int idx);
        case (mode)
            0:       return 1'b1;
            1:       return (idx % 2 == 0);
            2:       return 1'b0;
            3:       return (idx < 5);
            default: return (idx % 4 == 3);
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one conversion; SETTLE and post-window bits are driven 1 so any leak shows up.
    task automatic run_conv(input string name, input int mode, input int exp_count, input bit poke_start);
        int            rise;
        int            unstable;
        logic [RW-1:0] held;
        rise     = -1;
        unstable = 0;
        bit_in   = 1'b1;
        start    = 1'b1;
        step();
        start = 1'b0;
        chk({name, "_busy_after_start"}, int'(busy), 1);
        for (int e = 1; e <= 40; e++) begin
            int idx;
            idx    = e - 3;
            bit_in = (idx >= 0 && idx < N) ? gen(mode, idx) : 1'b1;
            start  = poke_start && (e == 10);
            step();
            if (result_valid) begin
                rise = e;
                break;
            end
        end
        start = 1'b0;
        chk({name, "_latency"}, rise, SKIP + N + 1);
        chk({name, "_result"}, int'(result), exp_res(exp_count));
        held = result;
        for (int i = 0; i < 10; i++) begin
            result_ready = 1'b0;
            start        = poke_start && (i == 3);
            bit_in       = ~bit_in;
            step();
            if (result !== held || result_valid !== 1'b1) unstable++;
        end
        start = 1'b0;
        chk({name, "_hold_stable"}, unstable, 0);
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        chk({name, "_valid_drop"}, int'(result_valid), 0);
        chk({name, "_idle_after"}, int'(busy), 0);
    endtask

    initial begin
        int stray;
        int seen;
        int last_cyc;
        n_rst        = 1'b0;
        bit_in       = 1'b0;
        start        = 1'b0;
        clear        = 1'b0;
        result_ready = 1'b0;

        vecs[0] = '{name: "all_ones",  mode: 0, exp_count: 16, poke_start: 1'b0};
        vecs[1] = '{name: "alternate", mode: 1, exp_count: 8,  poke_start: 1'b0};
        vecs[2] = '{name: "all_zeros", mode: 2, exp_count: 0,  poke_start: 1'b1};
        vecs[3] = '{name: "quarter",   mode: 4, exp_count: 4,  poke_start: 1'b0};

        step();
        step();
        chk("reset_busy", int'(busy), 0);
        chk("reset_valid", int'(result_valid), 0);
        chk("reset_result", int'(result), 0);
        n_rst = 1'b1;
        step();

        for (int v = 0; v < 4; v++)
            run_conv(vecs[v].name, vecs[v].mode, vecs[v].exp_count, vecs[v].poke_start);

        // Leave a non-zero result behind, then reset mid-COUNT.
        run_conv("pre_reset", 0, 16, 1'b0);
        bit_in = 1'b1;
        start  = 1'b1;
        step();
        start = 1'b0;
        for (int e = 1; e <= 10; e++) step();
        n_rst = 1'b0;
        #1;
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_valid", int'(result_valid), 0);
        chk("midreset_result", int'(result), 0);
        #2;
        n_rst = 1'b1;
        step();
        run_conv("after_reset", 3, 5, 1'b0);

        // Abort on the 10th COUNT sample.
        bit_in = 1'b1;
        start  = 1'b1;
        step();
        start = 1'b0;
        for (int e = 1; e <= 11; e++) step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clear_busy", int'(busy), 0);
        chk("clear_valid", int'(result_valid), 0);
        stray = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (result_valid || busy) stray++;
        end
        chk("clear_stays_idle", stray, 0);
        clear = 1'b1;
        start = 1'b1;
        step();
        clear = 1'b0;
        start = 1'b0;
        chk("clear_with_start_idle", int'(busy), 0);
        step();
        chk("clear_with_start_still_idle", int'(busy), 0);

        // Back-to-back with a ~0.25 density stream and the consumer always ready.
        result_ready = 1'b1;
        start        = 1'b1;
        seen         = 0;
        last_cyc     = -1;
        for (int cyc = 0; cyc < 150 && seen < 4; cyc++) begin
            bit_in = (cyc % 4 == 0);
            step();
            if (result_valid) begin
                int c;
                c = decoded_count(result);
                chk("b2b_within_tol", int'(c >= 0 && c <= 8), 1);
                if (last_cyc >= 0) chk("b2b_period", cyc - last_cyc, SKIP + N + 3);
                last_cyc = cyc;
                seen++;
            end
        end
        chk("b2b_results_seen", seen, 4);
        start        = 1'b0;
        result_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bitstream_decoder.md
# bitstream_decoder

Converts a single stochastic bitstream, such as the registered `neuron_output` of a neuron stage, back into a binary value by counting ones over a fixed window. It sits directly downstream of the neuron layer, one instance per neuron output. It exposes the result through a valid/ready handshake so the next layer's weight/bias loader, or the testbench scoreboard, can consume it. A configurable settle period discards the first bits after launch while generator LFSRs and the neuron output register fill.

## Interface
Parameters:
- `WINDOW_BITS`, default 8: window length N = 2^WINDOW_BITS cycles.
- `SKIP`, default 2: cycles discarded after `start` before counting begins (0 allowed).
- Derived `RES_W` = WINDOW_BITS+2: result width (count needs WINDOW_BITS+1 bits, plus a sign bit).

Ports:
- `clk`  in  1: system clock, rising edge.
- `n_rst`  in  1: asynchronous active-low reset.
- `bit_in`  in  1: stochastic bitstream, sampled every clk in COUNT.
- `start`  in  1: launch a conversion; honoured only in IDLE.
- `clear`  in  1: synchronous abort; returns to IDLE and drops `result_valid`.
- `busy`  out  1: high in SETTLE and COUNT.
- `result`  out  RES_W: converted value, stable while `result_valid`.
- `result_valid`  out  1: result available.
- `result_ready`  in  1: consumer accepts the result.

## Operation
- FSM states: IDLE, SETTLE, COUNT, HOLD.
- IDLE, `start`=1:
  - SKIP>0: go to SETTLE and load the settle counter with SKIP-1.
  - SKIP=0: go directly to COUNT.
  - In both cases clear the ones counter and the window counter.
- SETTLE: `bit_in` ignored; decrement the settle counter; at 0, go to COUNT.
- COUNT:
  - Each cycle: ones += `bit_in`; window counter increments.
  - On the Nth sample: register `result`, assert `result_valid`, go to HOLD.
- HOLD: `result` and `result_valid` held. When `result_ready`=1, deassert `result_valid` next cycle and go to IDLE.
- Arithmetic:
  - Ones count range is 0..N, unsigned, WINDOW_BITS+1 bits.
  - Unipolar `result` = count, zero-extended to RES_W.
  - No saturation is needed; the width guarantees no overflow.
- `clear` outranks every other input:
  - In any state it forces IDLE, clears the counters and drops `result_valid` the next cycle.
  - `clear` together with `start` in IDLE: stay in IDLE.
- `start` outside IDLE is ignored; it is not queued.
- `result_ready` with `result_valid` low is ignored.
- Reset values: state IDLE, `busy`=0, `result_valid`=0, `result`=0, all counters 0. Reset mid-conversion discards the partial count.

## Timing
- `start` high at edge t (IDLE).
- SETTLE occupies t+1..t+SKIP.
- `bit_in` is sampled at edges t+SKIP+1 .. t+SKIP+N.
- `result_valid` is high from cycle t+SKIP+N+1.
- Start-to-valid latency is SKIP+N+1 cycles.
- `busy` is high from t+1 through the last COUNT cycle.
- Handshake completes on the edge where `result_valid` and `result_ready` are both 1. The earliest next `start` is accepted one cycle later (in IDLE).
- Back-to-back throughput: one result per SKIP+N+3 cycles.

## Configuration
- Macro `BITSTREAM_DECODER_BIPOLAR_EN`.
- Defined: `result` is signed bipolar, `result` = 2·count − N, range −N..+N, two's complement in RES_W bits. Example: N=16 with all zeros gives −16, and 8 ones gives 0.
- Undefined: unipolar zero-extended count as above.
- FSM and timing are identical in both builds.

## Structure
- Shared package `bitstream_pkg`:
  - `decoder_state_t` enum (IDLE, SETTLE, COUNT, HOLD).
  - The `RES_W` derivation as a function of WINDOW_BITS.
  - The bipolar conversion function, reused by other decoders and the scoreboard.
- One sub-module, `window_counter`:
  - Clear plus enable inputs; a WINDOW_BITS+1-bit ones accumulator and a WINDOW_BITS-bit window counter.
  - A `last` flag, high on the Nth enabled cycle.
- The FSM, result register and handshake live in `bitstream_decoder`.

## Test plan
All scenarios use WINDOW_BITS=4 (N=16) and SKIP=2.
- Reset: assert `n_rst` low mid-COUNT → `busy`=0, `result_valid`=0, `result`=0 immediately; a restart produces a fresh count.
- `bit_in` constant 1, `start` at cycle 0 → `result_valid` rises at cycle 19; `result`=16 (bipolar build: +16); `result_ready` held 0 for 10 cycles keeps `result` stable.
- `bit_in` = 1,0 alternating, with 1s forced during SETTLE → `result`=8 (bipolar build: 0), showing the SETTLE bits are excluded.
- `bit_in` = 0 → `result`=0 (bipolar build: −16); `start` pulsed during COUNT and HOLD is ignored.
- `clear` at the 10th COUNT cycle → IDLE next cycle and no `result_valid`. `clear` together with `start` in IDLE → remains IDLE.
- Drive `bit_in` from a neuron stage whose target output is ~0.25, and run back-to-back conversions with `result_ready` tied 1 → a new `result` every 21 cycles, each within ±4 of 4.
